// File: rtl/fcb_pkg.sv
// fcb_pkg: shared state encoding and pixel type for the frame capture buffer
package fcb_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
endpackage

// File: rtl/fcb_if.sv
// fcb_if: VGA pixel stream in, RAM readback port out
interface fcb_if #(parameter int ADDR_W = 15);
    logic              READ_Request;
    logic [12:0]       H_Cont;
    logic [12:0]       V_Cont;
    logic [7:0]        input_Red;
    logic [7:0]        input_Green;
    logic [7:0]        input_Blue;
    logic [ADDR_W-1:0] read_address;
    logic [23:0]       output_q;
    modport master (
        output READ_Request, H_Cont, V_Cont, input_Red, input_Green, input_Blue, read_address,
        input  output_q
    );
    modport slave (
        input  READ_Request, H_Cont, V_Cont, input_Red, input_Green, input_Blue, read_address,
        output output_q
    );
endinterface

// File: rtl/fcb_sdp_ram.sv
// fcb_sdp_ram: single-clock simple dual-port RAM, registered read, read-during-write returns old data
module fcb_sdp_ram #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 24
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_q;
    // write port and registered read port share the clock
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_q <= r_mem[i_raddr];
    end
    assign o_rdata = r_q;
endmodule

// File: rtl/frame_capture_buffer.sv
// frame_capture_buffer: decimates one windowed RGB frame from the VGA stream into RAM
module frame_capture_buffer
    import fcb_pkg::*;
#(
    parameter int H_START    = 161,
    parameter int V_START    = 44,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int SCALE_LOG2 = 2,
    parameter int ADDR_W     = 15
) (
    input  logic       vga_clk,
    input  logic       reset,
    fcb_if.slave       pix,
    input  logic       capture_req,
    input  logic       abort,
    input  logic       continuous,
    input  logic       avg_mode,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frames_captured
);
    localparam int AW = 8 + SCALE_LOG2;
    localparam logic [12:0] MASK = 13'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'((IMG_W >> SCALE_LOG2) * (IMG_H >> SCALE_LOG2) - 1);

    state_t            r_state;
    logic              r_busy, r_done, r_cont, r_avg;
    logic [7:0]        r_count;
    logic [ADDR_W-1:0] r_addr, r_wr_addr;
    logic              r_wr_en, r_wr_last, r_done_p;
    rgb_t              r_wr_data;
    logic [AW-1:0]     r_acc_r, r_acc_g, r_acc_b;

    logic [12:0]       w_x, w_y, w_xm;
    logic              w_in, w_keep, w_start, w_proc, w_avg, w_wr;
    logic [ADDR_W-1:0] w_base;
    rgb_t              w_pix, w_avg_px;
    logic [AW-1:0]     w_sum_r, w_sum_g, w_sum_b;
    logic [23:0]       w_q;

    assign w_x     = pix.H_Cont - 13'(H_START);
    assign w_y     = pix.V_Cont - 13'(V_START);
    assign w_xm    = w_x & MASK;
    assign w_in    = pix.READ_Request && (w_x < 13'(IMG_W)) && (w_y < 13'(IMG_H));
    assign w_keep  = (w_y & MASK) == '0;
    assign w_start = w_in && (w_x == '0) && (w_y == '0);
    // only the frame-start pixel may leave ARMED; later frame starts inside CAPTURE are plain pixels
    assign w_proc  = !abort && w_in && w_keep && (r_state == CAPTURE || (r_state == ARMED && w_start));
    assign w_avg   = (r_state == ARMED) ? avg_mode : r_avg;
    assign w_wr    = w_proc && (w_avg ? (w_xm == MASK) : (w_xm == '0));
    assign w_base  = (r_state == ARMED) ? '0 : r_addr;
    assign w_pix   = '{r: pix.input_Red, g: pix.input_Green, b: pix.input_Blue};

    // running horizontal box sums, restarted on the first pixel of each group
    always_comb begin
        w_sum_r    = (w_xm == '0 ? '0 : r_acc_r) + AW'(w_pix.r);
        w_sum_g    = (w_xm == '0 ? '0 : r_acc_g) + AW'(w_pix.g);
        w_sum_b    = (w_xm == '0 ? '0 : r_acc_b) + AW'(w_pix.b);
        w_avg_px.r = 8'(w_sum_r >> SCALE_LOG2);
        w_avg_px.g = 8'(w_sum_g >> SCALE_LOG2);
        w_avg_px.b = 8'(w_sum_b >> SCALE_LOG2);
    end

    // datapath: write pipeline stage and accumulators, no reset needed
    always_ff @(posedge vga_clk) begin
        if (w_wr) begin
            r_wr_addr <= w_base;
            r_wr_data <= w_avg ? w_avg_px : w_pix;
        end
        if (w_proc) begin
            r_acc_r <= w_sum_r;
            r_acc_g <= w_sum_g;
            r_acc_b <= w_sum_b;
        end
    end

    // capture FSM with registered busy/frame_done/counter and write-enable pipeline
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_last <= 1'b0;
            r_done_p  <= 1'b0;
            r_cont    <= 1'b0;
            r_avg     <= 1'b0;
        end else begin
            r_wr_en   <= w_wr;
            r_wr_last <= w_wr && (w_base == LAST);
            r_done_p  <= r_wr_en && r_wr_last && !abort;
            r_done    <= 1'b0;
            if (w_proc) r_addr <= w_base + ADDR_W'(w_wr);
            if (abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else if ((r_state == IDLE || r_state == DONE) && capture_req) begin
                r_state <= ARMED;
                r_busy  <= 1'b1;
                if (r_state == IDLE) r_cont <= continuous;
            end else if (r_state == ARMED && w_proc) begin
                r_state <= CAPTURE;
                r_avg   <= avg_mode;
            end else if (r_state == CAPTURE && r_done_p) begin
                // continuous mode re-arms straight away so busy never drops between frames
                r_state <= r_cont ? ARMED : DONE;
                r_busy  <= r_cont;
                r_done  <= 1'b1;
                r_count <= r_count + 8'd1;
            end
        end
    end

    fcb_sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(24)) u_ram (
        .i_clk   (vga_clk),
        .i_we    (r_wr_en && !abort && !reset),
        .i_waddr (r_wr_addr),
        .i_wdata (r_wr_data),
        .i_raddr (pix.read_address),
        .o_rdata (w_q)
    );

    assign pix.output_q    = w_q;
    assign busy            = r_busy;
    assign frame_done      = r_done;
    assign frames_captured = r_count;
endmodule

// File: tb/tb_frame_capture_buffer.sv
// tb_frame_capture_buffer: directed frames on a 32x16 window, decimation 4 -> 8x4 output words
module tb_frame_capture_buffer;
    logic       clk = 1'b0;
    logic       reset, capture_req, abort, continuous, avg_mode;
    logic       busy, frame_done;
    logic [7:0] frames_captured;
    int         n_cmp = 0, n_bad = 0;
    int         done_cnt = 0, gap = 0;
    bit         watch = 0, cont_mode = 0;
    logic       s_busy, s_done;
    logic [7:0] s_cnt;
    logic [23:0] q;

    fcb_if #(.ADDR_W(6)) bus ();

    frame_capture_buffer #(
        .H_START(161), .V_START(44), .IMG_W(32), .IMG_H(16), .SCALE_LOG2(2), .ADDR_W(6)
    ) dut (
        .vga_clk(clk), .reset(reset), .pix(bus.slave),
        .capture_req(capture_req), .abort(abort), .continuous(continuous), .avg_mode(avg_mode),
        .busy(busy), .frame_done(frame_done), .frames_captured(frames_captured)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rr, input int h, input int v, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic ab, input logic cr, input logic rs);
        @(negedge clk);
        if (reset) begin
            s_busy = busy;
            s_done = frame_done;
            s_cnt  = frames_captured;
        end
        if (frame_done) begin
            done_cnt++;
            if (!cont_mode) watch = 0;
        end else if (watch && !busy) gap++;
        bus.READ_Request = rr;
        bus.H_Cont       = 13'(h);
        bus.V_Cont       = 13'(v);
        bus.input_Red    = r;
        bus.input_Green  = g;
        bus.input_Blue   = b;
        abort            = ab;
        capture_req      = cr;
        reset            = rs;
    endtask

    task automatic frame(input bit avgp, input int ev_v, input int ev_k);
        for (int v = 42; v < 62; v++) begin
            for (int h = 158; h < 196; h++) begin
                int x, y;
                bit inw, ev;
                logic [7:0] r, g, b;
                x   = h - 161;
                y   = v - 44;
                inw = h >= 161 && h < 193 && v >= 44 && v < 60;
                ev  = v == ev_v && h == 170;
                r   = !inw ? 8'hFF : 8'(x);
                g   = !inw ? 8'hFF : avgp ? 8'h33 : 8'(y);
                b   = !inw ? 8'hFF : avgp ? 8'hC4 : 8'h5A;
                if (inw && x == 5) step(1'b0, h, v, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
                step(1'b1, h, v, r, g, b, ev && ev_k == 1, ev && ev_k == 2, ev && ev_k == 3);
            end
        end
        step(1'b0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic arm(input logic cont, input logic avg);
        @(negedge clk);
        capture_req = 1'b1;
        continuous  = cont;
        avg_mode    = avg;
        @(negedge clk);
        capture_req = 1'b0;
        watch       = 1;
        cont_mode   = cont;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic rd(input int a, output logic [23:0] d);
        @(negedge clk);
        bus.read_address = 6'(a);
        @(negedge clk);
        d = bus.output_q;
    endtask

    function automatic logic [23:0] sub_px(input int a);
        return {8'(4 * (a % 8)), 8'(4 * (a / 8)), 8'h5A};
    endfunction

    function automatic logic [23:0] avg_px(input int a);
        return {8'(4 * (a % 8) + 1), 8'h33, 8'hC4};
    endfunction

    initial begin
        reset = 1'b1; capture_req = 1'b0; abort = 1'b0; continuous = 1'b0; avg_mode = 1'b0;
        bus.READ_Request = 1'b0; bus.H_Cont = '0; bus.V_Cont = '0;
        bus.input_Red = '0; bus.input_Green = '0; bus.input_Blue = '0; bus.read_address = '0;
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", frame_done, 0);
        check("rst count", frames_captured, 0);
        reset = 1'b0;

        arm(1'b0, 1'b0);
        check("t1 busy armed", busy, 1);
        frame(1'b0, -1, 0);
        check("t1 done pulses", done_cnt, 1);
        check("t1 count", frames_captured, 1);
        check("t1 busy gap", gap, 0);
        check("t1 busy after", busy, 0);
        rd(9, q);
        check("t1 addr9", q, {8'd4, 8'd4, 8'h5A});
        for (int a = 0; a < 32; a++) begin
            rd(a, q);
            check($sformatf("t1 addr%0d", a), q, sub_px(a));
        end

        arm(1'b0, 1'b1);
        frame(1'b1, -1, 0);
        check("t2 done pulses", done_cnt, 2);
        check("t2 count", frames_captured, 2);
        rd(0, q);
        check("t2 addr0", q, {8'd1, 8'h33, 8'hC4});
        rd(1, q);
        check("t2 addr1", q, {8'd5, 8'h33, 8'hC4});
        for (int a = 0; a < 32; a++) begin
            rd(a, q);
            check($sformatf("t2 addr%0d", a), q, avg_px(a));
        end

        pulse_abort();
        check("t4 idle before", busy, 0);
        arm(1'b1, 1'b0);
        frame(1'b0, -1, 0);
        frame(1'b0, -1, 0);
        frame(1'b0, -1, 0);
        check("t4 done pulses", done_cnt, 5);
        check("t4 count", frames_captured, 5);
        check("t4 busy gap", gap, 0);
        check("t4 still armed", busy, 1);
        pulse_abort();
        check("t4 abort busy", busy, 0);
        rd(31, q);
        check("t4 addr31", q, sub_px(31));

        arm(1'b0, 1'b1);
        watch = 0;
        frame(1'b1, 50, 1);
        check("t5 no done", done_cnt, 5);
        check("t5 count", frames_captured, 5);
        check("t5 busy", busy, 0);
        rd(15, q);
        check("t5 partial addr15", q, avg_px(15));
        rd(16, q);
        check("t5 old addr16", q, sub_px(16));
        arm(1'b0, 1'b0);
        frame(1'b0, -1, 0);
        check("t5 done pulses", done_cnt, 6);
        check("t5 count after", frames_captured, 6);
        rd(15, q);
        check("t5 addr15 after", q, sub_px(15));

        arm(1'b0, 1'b0);
        frame(1'b0, 50, 2);
        check("t6 req ignored done", done_cnt, 7);
        check("t6 count", frames_captured, 7);
        check("t6 busy gap", gap, 0);
        arm(1'b0, 1'b0);
        watch = 0;
        frame(1'b0, 50, 3);
        check("t6 rst busy", s_busy, 0);
        check("t6 rst done", s_done, 0);
        check("t6 rst count", s_cnt, 0);
        check("t6 no done", done_cnt, 7);
        check("t6 count end", frames_captured, 0);
        check("t6 busy end", busy, 0);
        rd(31, q);
        check("t6 ram kept", q, sub_px(31));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
